// File: rtl/matrix_vector_ctrl.sv
// Sequences one ROWS-row matrix-vector pass: selector clear/prime, dot-unit start, result capture.
// Latency: 1 + ROWS*(SEL_LAT+1+k) cycles from accepted start to done, where k is the dot-unit latency.
// Backpressure: none; a row waits for dot_valid up to TIMEOUT cycles, then aborts with the sticky err flag.
//
// Ports:
//   clk, rst                   clock and synchronous active-low reset
//   start, abort               pass request (IDLE only) and cancel (any other state)
//   sel_clr, sel_en, sel_ready selector clear, enable and advance-one-row pulse
//   dot_start                  dot unit start pulse
//   dot_valid, dot_result      dot unit result handshake
//   result_vec                 packed results, row r at [r*RES_W +: RES_W]
//   busy, done, err            status to the top-level controller
module matrix_vector_ctrl #(
  parameter int ROWS    = 16,
  parameter int RES_W   = 32,
  parameter int SEL_LAT = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  sel_clr,
  output logic                  sel_en,
  output logic                  sel_ready,
  output logic                  dot_start,
  input  logic                  dot_valid,
  input  logic [RES_W-1:0]      dot_result,
  output logic [ROWS*RES_W-1:0] result_vec,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int WAIT_W  = $clog2(TIMEOUT + 1);
  localparam int PRIME_W = (SEL_LAT > 1) ? $clog2(SEL_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_PRIME,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ROW_W-1:0]      row_idx_q, row_idx_d;
  logic [PRIME_W-1:0]    prime_cnt_q, prime_cnt_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                  err_q, err_d;
  logic [ROWS*RES_W-1:0] result_vec_q, result_vec_d;
  logic                  store;

  logic sel_clr_q, sel_clr_d;
  logic sel_en_q, sel_en_d;
  logic sel_ready_q, sel_ready_d;
  logic dot_start_q, dot_start_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Next-state and datapath
  always_comb begin
    state_d      = state_q;
    row_idx_d    = row_idx_q;
    prime_cnt_d  = prime_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;
    result_vec_d = result_vec_q;
    store        = 1'b0;

    // Abort wins over a coincident dot_valid, so nothing is stored on that cycle.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_CLR;
            row_idx_d = '0;
            err_d     = 1'b0;
          end
        end
        S_CLR: begin
          state_d     = S_PRIME;
          prime_cnt_d = '0;
        end
        S_PRIME: begin
          // Stay SEL_LAT cycles so the selector row has settled before dot_start.
          if (prime_cnt_q == PRIME_W'(SEL_LAT - 1)) begin
            state_d = S_ISSUE;
          end else begin
            prime_cnt_d = prime_cnt_q + 1'b1;
          end
        end
        S_ISSUE: begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
        S_WAIT: begin
          if (dot_valid) begin
            store = 1'b1;
            result_vec_d[int'(row_idx_q)*RES_W +: RES_W] = dot_result;
            if (row_idx_q == ROW_W'(ROWS - 1)) begin
              state_d = S_DONE;
            end else begin
              row_idx_d   = row_idx_q + 1'b1;
              state_d     = S_PRIME;
              prime_cnt_d = '0;
            end
          end else if (wait_cnt_q == WAIT_W'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (wait_cnt_q != '1) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Outputs are decoded from the next state so the flops line up with the state they describe.
    sel_clr_d   = (state_d == S_CLR);
    sel_en_d    = (state_d == S_PRIME) || (state_d == S_ISSUE) || (state_d == S_WAIT);
    dot_start_d = (state_d == S_ISSUE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    // Advance pulse follows every accepted store, including the last row.
    sel_ready_d = store;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      row_idx_q    <= '0;
      prime_cnt_q  <= '0;
      wait_cnt_q   <= '0;
      err_q        <= 1'b0;
      result_vec_q <= '0;
      sel_clr_q    <= 1'b0;
      sel_en_q     <= 1'b0;
      sel_ready_q  <= 1'b0;
      dot_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_idx_q    <= row_idx_d;
      prime_cnt_q  <= prime_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      err_q        <= err_d;
      result_vec_q <= result_vec_d;
      sel_clr_q    <= sel_clr_d;
      sel_en_q     <= sel_en_d;
      sel_ready_q  <= sel_ready_d;
      dot_start_q  <= dot_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign sel_clr    = sel_clr_q;
  assign sel_en     = sel_en_q;
  assign sel_ready  = sel_ready_q;
  assign dot_start  = dot_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign result_vec = result_vec_q;

endmodule

// File: tb/tb_matrix_vector_ctrl.sv
// Directed bench for matrix_vector_ctrl with a behavioural dot unit.
// Latency: n/a.
// Backpressure: n/a.
module tb_matrix_vector_ctrl;

  localparam int ROWS  = 16;
  localparam int RES_W = 32;
  localparam int VW    = ROWS * RES_W;

  logic          clk = 1'b0;
  logic          rst, start, abort, dot_valid;
  logic [31:0]   dot_result;
  logic          sel_clr, sel_en, sel_ready, dot_start, busy, done, err;
  logic [VW-1:0] result_vec;

  always #5 clk = ~clk;

  matrix_vector_ctrl #(.ROWS(16), .RES_W(32), .SEL_LAT(2), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .sel_clr(sel_clr), .sel_en(sel_en), .sel_ready(sel_ready), .dot_start(dot_start),
    .dot_valid(dot_valid), .dot_result(dot_result), .result_vec(result_vec),
    .busy(busy), .done(done), .err(err)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int ds_cnt, sr_cnt, done_cnt, done_cyc, clr_cnt, busy_lows;
  int ds_cyc[ROWS];
  int mode = 0, base = 100, silent_row = -1;
  bit pend = 1'b0;
  int kcnt, pend_row;
  logic [VW-1:0] expv;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int klat(input int r);
    return (mode == 1) ? (((r % 2) == 0) ? 1 : 7) : 1;
  endfunction

  function automatic logic [31:0] dval(input int r);
    if (mode == 1) return ((r % 2) == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    return 32'(r + base);
  endfunction

  task automatic clr_counts();
    ds_cnt = 0; sr_cnt = 0; done_cnt = 0; done_cyc = 0; clr_cnt = 0; busy_lows = 0; pend = 1'b0;
  endtask

  // One clock: observe outputs at the falling edge, then drive the dot-unit model.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (sel_ready === 1'b1) sr_cnt++;
    if (sel_clr === 1'b1) clr_cnt++;
    if (busy !== 1'b1) busy_lows++;
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    dot_valid = 1'b0;
    if (pend) begin
      kcnt--;
      if (kcnt == 0) begin
        pend = 1'b0;
        dot_valid = 1'b1;
        dot_result = dval(pend_row);
      end
    end
    if (dot_start === 1'b1) begin
      if (ds_cnt < ROWS) ds_cyc[ds_cnt] = cyc;
      kcnt = klat(ds_cnt);
      pend_row = ds_cnt;
      pend = (ds_cnt != silent_row);
      ds_cnt++;
    end
  endtask

  task automatic run_to_done(input int bound);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int s_cyc, idle_cyc, n;
    rst = 1'b0; start = 1'b0; abort = 1'b0; dot_valid = 1'b0; dot_result = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_sel_clr", sel_clr, 0);
    chk("rst_sel_en", sel_en, 0);
    chk("rst_sel_ready", sel_ready, 0);
    chk("rst_dot_start", dot_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result_vec", result_vec, 0);
    rst = 1'b1;
    tick();

    // dot_valid while idle must not store
    dot_valid = 1'b1; dot_result = 32'hDEAD_BEEF;
    tick();
    tick();
    chk("idle_dot_valid_ignored", result_vec, 0);
    chk("idle_busy", busy, 0);

    // Nominal pass, k=1, results r+100
    mode = 0; base = 100; silent_row = -1;
    clr_counts();
    start = 1'b1;
    tick();
    start = 1'b0;
    s_cyc = cyc;
    chk("nom_clr_pulse", {sel_clr, sel_en, busy}, 3'b101);
    run_to_done(200);
    chk("nom_done_count", done_cnt, 1);
    chk("nom_done_latency", done_cyc - s_cyc, 65);
    chk("nom_dot_start_count", ds_cnt, 16);
    chk("nom_sel_ready_count", sr_cnt, 16);
    chk("nom_busy_throughout", busy_lows, 0);
    for (int r = 0; r < ROWS; r++) expv[r*RES_W +: RES_W] = 32'(r + 100);
    chk("nom_result_vec", result_vec, expv);
    tick();
    chk("nom_idle_after_done", {busy, done}, 2'b00);

    // Variable latency, extreme signed values
    mode = 1;
    clr_counts();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done(400);
    chk("var_done_count", done_cnt, 1);
    for (int r = 0; r < ROWS; r++)
      expv[r*RES_W +: RES_W] = ((r % 2) == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    chk("var_result_vec", result_vec, expv);
    for (int r = 0; r < ROWS - 1; r++)
      chk($sformatf("var_spacing_row%0d", r), ds_cyc[r+1] - ds_cyc[r], (((r % 2) == 0) ? 1 : 7) + 3);
    tick();

    // Timeout on row 5
    mode = 0; base = 100; silent_row = 5;
    clr_counts();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 400) begin tick(); n++; end
    idle_cyc = cyc;
    chk("to_back_to_idle", busy, 0);
    chk("to_err", err, 1);
    chk("to_no_done", done_cnt, 0);
    chk("to_dot_starts", ds_cnt, 6);
    chk("to_wait_length_in_range",
        ((idle_cyc - ds_cyc[5]) >= 256) && ((idle_cyc - ds_cyc[5]) <= 258), 1);
    for (int r = 0; r < 5; r++) expv[r*RES_W +: RES_W] = 32'(r + 100);
    chk("to_partial_result_vec", result_vec, expv);
    tick();
    chk("to_err_sticky", err, 1);

    // Next start clears err, full pass completes
    silent_row = -1;
    clr_counts();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_err_cleared_on_start", err, 0);
    run_to_done(200);
    chk("to_recover_done", done_cnt, 1);
    for (int r = 0; r < ROWS; r++) expv[r*RES_W +: RES_W] = 32'(r + 100);
    chk("to_recover_result_vec", result_vec, expv);
    tick();

    // Abort in WAIT of row 3, coincident with dot_valid
    base = 500;
    clr_counts();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (ds_cnt < 4 && n < 100) begin tick(); n++; end
    chk("ab_reached_row3", ds_cnt, 4);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_sel_en", sel_en, 0);
    chk("ab_no_sel_ready", sel_ready, 0);
    chk("ab_no_done", done_cnt, 0);
    chk("ab_err_unchanged", err, 0);
    for (int r = 0; r < 3; r++) expv[r*RES_W +: RES_W] = 32'(r + 500);
    chk("ab_result_vec", result_vec, expv);
    tick();

    // Reset in PRIME of row 8
    base = 700;
    clr_counts();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (ds_cnt < 8 && n < 100) begin tick(); n++; end
    tick();
    tick();
    chk("rm_in_prime_row8", {sel_en, sel_ready, dot_start}, 3'b110);
    rst = 1'b0;
    tick();
    chk("rm_outputs_zero", {sel_clr, sel_en, sel_ready, dot_start, busy, done, err}, 7'b0);
    chk("rm_result_vec_zero", result_vec, 0);
    chk("rm_no_done", done_cnt, 0);
    rst = 1'b1;
    tick();

    // Start held high across a whole pass
    base = 0;
    clr_counts();
    start = 1'b1;
    tick();
    run_to_done(200);
    chk("sh_first_done", done_cnt, 1);
    chk("sh_single_clear", clr_cnt, 1);
    for (int r = 0; r < ROWS; r++) expv[r*RES_W +: RES_W] = 32'(r);
    chk("sh_result_vec", result_vec, expv);
    tick();
    chk("sh_idle_after_done", busy, 0);
    clr_counts();
    tick();
    chk("sh_second_pass_clr", {sel_clr, busy}, 2'b11);
    start = 1'b0;
    run_to_done(200);
    chk("sh_second_done", done_cnt, 1);
    repeat (3) tick();
    chk("sh_no_third_pass", {busy, 32'(clr_cnt)}, {1'b0, 32'd1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
